// File: rtl/twiddle_gen_if.sv
// Request/response bundle between an FFT datapath and the twiddle generator.
// The master issues twiddle requests with their FFT configuration; the slave
// returns the complex twiddle factor with the request index echoed back.
interface twiddle_gen_if #(
    parameter int N_MAX = 1024,
    parameter int WIDTH = 16
);
    localparam int LOG2N_MAX = $clog2(N_MAX);
    localparam int CFG_W     = $clog2(LOG2N_MAX + 1);
    localparam int IDX_W     = LOG2N_MAX - 1;

    logic [CFG_W-1:0]        cfg_log2n;
    logic                    cfg_inverse;
    logic                    req_valid;
    logic                    req_ready;
    logic [IDX_W-1:0]        req_idx;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic signed [WIDTH-1:0] rsp_re;
    logic signed [WIDTH-1:0] rsp_im;
    logic [IDX_W-1:0]        rsp_idx;

    modport master (
        output cfg_log2n, cfg_inverse, req_valid, req_idx, rsp_ready,
        input  req_ready, rsp_valid, rsp_re, rsp_im, rsp_idx
    );

    modport slave (
        input  cfg_log2n, cfg_inverse, req_valid, req_idx, rsp_ready,
        output req_ready, rsp_valid, rsp_re, rsp_im, rsp_idx
    );
endinterface

// File: rtl/twiddle_gen.sv
// Runtime-configurable FFT twiddle generator. A single quarter-wave cosine
// table sized for N_MAX serves every FFT size 2^L <= N_MAX, forward or
// inverse. Two pipeline stages (fold/accept, then table read) sit behind a
// valid/ready handshake with full backpressure.
module twiddle_gen #(
    parameter int N_MAX     = 1024,
    parameter int WIDTH     = 16,
    parameter int LOG2N_MAX = $clog2(N_MAX)
) (
    input  logic         clk,
    input  logic         rst,
    twiddle_gen_if.slave bus
);
    localparam int  IDX_W = LOG2N_MAX - 1;
    localparam int  CFG_W = $clog2(LOG2N_MAX + 1);
    localparam int  Q     = N_MAX / 4;
    localparam real PI    = 3.14159265358979323846;
    localparam real AMP   = real'((1 << (WIDTH - 1)) - 1);

    // Quarter-wave addresses run 0..Q, which fits in the index width.
    localparam logic [IDX_W-1:0] Q_V       = IDX_W'(Q);
    localparam logic [CFG_W-1:0] L_MAX_V   = CFG_W'(LOG2N_MAX);
    localparam logic [CFG_W-1:0] L_MIN_V   = CFG_W'(2);

    // cos(2*pi*j/N_MAX) by Taylor series (argument is at most pi/2, so the
    // series converges fast), scaled by A and rounded half away from zero.
    // All entries are non-negative, so adding 0.5 before truncation rounds.
    function automatic logic [WIDTH-1:0] cos_entry(input int j);
        real x;
        real term;
        real sum;
        x    = 2.0 * PI * real'(j) / real'(N_MAX);
        term = 1.0;
        sum  = 1.0;
        for (int n = 1; n < 24; n++) begin
            term = -term * x * x / real'((2 * n - 1) * (2 * n));
            sum  = sum + term;
        end
        if (sum < 0.0) begin
            sum = 0.0;
        end
        return WIDTH'($rtoi(sum * AMP + 0.5));
    endfunction

    // Quarter-wave ROM, elaborated from the constant function.
    logic [WIDTH-1:0] rom [0:Q];

    for (genvar gi = 0; gi <= Q; gi++) begin : g_rom
        localparam logic [WIDTH-1:0] ENTRY = cos_entry(gi);
        assign rom[gi] = ENTRY;
    end

    // Pipeline state
    logic             s1_valid_q,   s1_valid_d;
    logic [IDX_W-1:0] s1_re_addr_q, s1_re_addr_d;
    logic [IDX_W-1:0] s1_im_addr_q, s1_im_addr_d;
    logic             s1_neg_re_q,  s1_neg_re_d;
    logic             s1_neg_im_q,  s1_neg_im_d;
    logic [IDX_W-1:0] s1_idx_q,     s1_idx_d;
    logic             rsp_valid_q,  rsp_valid_d;
    logic [WIDTH-1:0] rsp_re_q,     rsp_re_d;
    logic [WIDTH-1:0] rsp_im_q,     rsp_im_d;
    logic [IDX_W-1:0] rsp_idx_q,    rsp_idx_d;

    // Folding results for the request currently presented
    logic [CFG_W-1:0] l_eff;
    logic [CFG_W-1:0] shift;
    logic [IDX_W-1:0] k_mask;
    logic [IDX_W-1:0] m;
    logic [IDX_W-1:0] m_hi;
    logic [IDX_W-1:0] re_addr;
    logic [IDX_W-1:0] im_addr;
    logic             neg_re;
    logic             neg_im;

    // Handshake
    logic             s2_load;
    logic             req_ready;
    logic             req_fire;
    logic [WIDTH-1:0] rom_re;
    logic [WIDTH-1:0] rom_im;

    assign s2_load       = !rsp_valid_q || bus.rsp_ready;
    assign req_ready     = !rst && (!s1_valid_q || s2_load);
    assign req_fire      = bus.req_valid && req_ready;
    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_re    = rsp_re_q;
    assign bus.rsp_im    = rsp_im_q;
    assign bus.rsp_idx   = rsp_idx_q;

    // Sanitise L, mask k, scale to the N_MAX grid and fold onto the quarter wave.
    always_comb begin
        l_eff = bus.cfg_log2n;
        if (bus.cfg_log2n < L_MIN_V || bus.cfg_log2n > L_MAX_V) begin
            l_eff = L_MAX_V;
        end
        shift  = L_MAX_V - l_eff;
        // Keeping IDX_W - shift = L-1 low bits is exactly k mod 2^(L-1).
        k_mask = bus.req_idx & ({IDX_W{1'b1}} >> shift);
        m      = k_mask << shift;
        m_hi   = m - Q_V;
        if (m < Q_V) begin
            re_addr = m;
            im_addr = Q_V - m;
            neg_re  = 1'b0;
        end else begin
            re_addr = Q_V - m_hi;
            im_addr = m_hi;
            neg_re  = 1'b1;
        end
        // Over the first half-turn the sine term is always non-negative, so
        // the forward imaginary part is always negated and inverse undoes it.
        neg_im = !bus.cfg_inverse;
    end

    assign rom_re = rom[s1_re_addr_q];
    assign rom_im = rom[s1_im_addr_q];

    // Next-state for both stages: stage 1 captures on accept, stage 2 loads
    // whenever its output is empty or being consumed.
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_re_addr_d = s1_re_addr_q;
        s1_im_addr_d = s1_im_addr_q;
        s1_neg_re_d  = s1_neg_re_q;
        s1_neg_im_d  = s1_neg_im_q;
        s1_idx_d     = s1_idx_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_re_d     = rsp_re_q;
        rsp_im_d     = rsp_im_q;
        rsp_idx_d    = rsp_idx_q;

        if (s2_load) begin
            rsp_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                rsp_re_d  = s1_neg_re_q ? (WIDTH'(0) - rom_re) : rom_re;
                rsp_im_d  = s1_neg_im_q ? (WIDTH'(0) - rom_im) : rom_im;
                rsp_idx_d = s1_idx_q;
            end
            s1_valid_d = 1'b0;
        end

        if (req_fire) begin
            s1_valid_d   = 1'b1;
            s1_re_addr_d = re_addr;
            s1_im_addr_d = im_addr;
            s1_neg_re_d  = neg_re;
            s1_neg_im_d  = neg_im;
            s1_idx_d     = bus.req_idx;
        end
    end

    // State registers; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_re_addr_q <= '0;
            s1_im_addr_q <= '0;
            s1_neg_re_q  <= 1'b0;
            s1_neg_im_q  <= 1'b0;
            s1_idx_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_re_q     <= '0;
            rsp_im_q     <= '0;
            rsp_idx_q    <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_re_addr_q <= s1_re_addr_d;
            s1_im_addr_q <= s1_im_addr_d;
            s1_neg_re_q  <= s1_neg_re_d;
            s1_neg_im_q  <= s1_neg_im_d;
            s1_idx_q     <= s1_idx_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_re_q     <= rsp_re_d;
            rsp_im_q     <= rsp_im_d;
            rsp_idx_q    <= rsp_idx_d;
        end
    end
endmodule

// File: tb/tb_twiddle_gen.sv
// Testbench for twiddle_gen: directed test-plan values, per-request config
// sampling, illegal-L handling, full sweep and random traffic against a
// floating-point twiddle model, backpressure/hold behaviour and reset flush.
module tb_twiddle_gen;
    localparam int  N   = 1024;
    localparam int  W   = 16;
    localparam int  LM  = 10;
    localparam real PI  = 3.14159265358979323846;
    localparam real A   = 32767.0;

    logic clk;
    logic rst;

    twiddle_gen_if #(.N_MAX(N), .WIDTH(W)) bus ();

    twiddle_gen #(.N_MAX(N), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int re;
        int im;
        int idx;
        bit tol;
        int acc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_rsp   = 0;
    int   cyc     = 0;
    int   last_lat = 0;
    bit   last_acc = 0;
    bit   rand_rdy = 0;
    bit   hold_chk = 0;
    int   held_re, held_im, held_idx;
    int   nxt_re, nxt_im;
    bit   nxt_tol;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input logic signed [31:0] obs, input int exp);
        bit ok;
        n_tests++;
        ok = !$isunknown(obs) && ((int'(obs) - exp) <= 1) && ((exp - int'(obs)) <= 1);
        assert (ok === 1'b1) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d (+/-1)", tag, obs, exp);
        end
    endtask

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    // Reference: the twiddle W = exp(-j*2*pi*k/2^L) straight from its definition.
    function automatic void model(input int k, input int l, input bit inv,
                                  output int re, output int im);
        int  ll;
        int  km;
        real ang;
        ll  = (l < 2 || l > LM) ? LM : l;
        km  = k % (1 << (ll - 1));
        ang = 2.0 * PI * real'(km) / real'(1 << ll);
        re  = rnd(A * $cos(ang));
        im  = -rnd(A * $sin(ang));
        if (inv) im = -im;
    endfunction

    // One clock cycle: inputs are already driven; observe handshakes mid-cycle.
    task automatic tick();
        exp_t e;
        if (rand_rdy) bus.rsp_ready = 1'($urandom_range(0, 1));
        #1;
        cyc++;
        if (hold_chk) begin
            chk("hold_valid", bus.rsp_valid, 1);
            chk("hold_re", $signed(bus.rsp_re), held_re);
            chk("hold_im", $signed(bus.rsp_im), held_im);
            chk("hold_idx", bus.rsp_idx, held_idx);
        end
        // Input side stalls only when both stages hold data and output is blocked.
        chk("req_ready", bus.req_ready, (sb.size() == 2 && !bus.rsp_ready) ? 0 : 1);
        if (bus.rsp_valid === 1'b1 && bus.rsp_ready) begin
            n_tests++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL stale_rsp: got response idx %0d expected none", bus.rsp_idx);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rsp_idx", bus.rsp_idx, e.idx);
                if (e.tol) begin
                    chk_tol($sformatf("re k=%0d", e.idx), $signed(bus.rsp_re), e.re);
                    chk_tol($sformatf("im k=%0d", e.idx), $signed(bus.rsp_im), e.im);
                end else begin
                    chk($sformatf("re k=%0d", e.idx), $signed(bus.rsp_re), e.re);
                    chk($sformatf("im k=%0d", e.idx), $signed(bus.rsp_im), e.im);
                end
                last_lat = cyc - e.acc;
                n_rsp++;
            end
        end
        last_acc = 0;
        if (bus.req_valid && bus.req_ready === 1'b1) begin
            sb.push_back('{re: nxt_re, im: nxt_im, idx: int'(bus.req_idx), tol: nxt_tol, acc: cyc});
            last_acc = 1;
        end
        hold_chk = (bus.rsp_valid === 1'b1) && !bus.rsp_ready;
        held_re  = $signed(bus.rsp_re);
        held_im  = $signed(bus.rsp_im);
        held_idx = bus.rsp_idx;
        @(negedge clk);
    endtask

    task automatic send(input int k, input int l, input bit inv,
                        input int ere, input int eim, input bit tol);
        bus.req_valid   = 1'b1;
        bus.req_idx     = 9'(k);
        bus.cfg_log2n   = 4'(l);
        bus.cfg_inverse = inv;
        nxt_re  = ere;
        nxt_im  = eim;
        nxt_tol = tol;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (last_acc) return;
        end
        n_tests++;
        n_fail++;
        $error("FAIL send_timeout: got no accept for k=%0d expected accept within 64 cycles", k);
    endtask

    task automatic send_model(input int k, input int l, input bit inv);
        int re, im;
        model(k, l, inv, re, im);
        send(k, l, inv, re, im, 1'b1);
    endtask

    task automatic drain();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 400 && sb.size() > 0; i++) tick();
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int base;
        rst             = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_idx     = '0;
        bus.cfg_log2n   = 4'd8;
        bus.cfg_inverse = 1'b0;
        bus.rsp_ready   = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_re", $signed(bus.rsp_re), 0);
        chk("rst_rsp_im", $signed(bus.rsp_im), 0);
        chk("rst_rsp_idx", bus.rsp_idx, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", bus.req_ready, 1);
        @(negedge clk);

        // Directed forward values, L=8, back-to-back
        send(0,   8, 0, 32767, 0,      0);
        send(1,   8, 0, 32757, -804,   0);
        send(32,  8, 0, 23170, -23170, 0);
        send(64,  8, 0, 0,     -32767, 0);
        send(127, 8, 0, -32757, -804,  0);
        // Per-request configuration sampling
        send(1, 10, 0, 32766, -201, 0);
        send(1, 8,  0, 32757, -804, 0);
        // Inverse
        send(32, 8, 1, 23170, 23170, 0);
        // Illegal L values fall back to L=10
        send(1, 1,  0, 32766, -201, 0);
        send(1, 15, 0, 32766, -201, 0);
        // Index masking: 200 mod 128 = 72
        send_model(200, 8, 0);
        drain();

        // Full sweep of every legal size and index
        for (int l = 2; l <= LM; l++) begin
            for (int k = 0; k < (1 << (l - 1)); k++) begin
                send_model(k, l, 1'($urandom_range(0, 1)));
            end
        end
        drain();

        // Backpressure: continuous stream of k = 0..15 with random rsp_ready
        rand_rdy = 1;
        base = n_rsp;
        for (int k = 0; k < 16; k++) send_model(k, LM, 0);
        drain();
        chk("bp_rsp_count", n_rsp - base, 16);

        // Random traffic, including illegal L and out-of-range k
        for (int i = 0; i < 300; i++) begin
            send_model($urandom_range(0, 511), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
        end
        drain();
        rand_rdy = 0;

        // Reset with two requests in flight
        bus.rsp_ready = 1'b0;
        send_model(3, 8, 0);
        send_model(5, 8, 0);
        bus.req_valid = 1'b0;
        chk("inflight_rsp_valid", bus.rsp_valid, 1);
        chk("inflight_req_ready", bus.req_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("flush_rsp_valid", bus.rsp_valid, 0);
        chk("flush_req_ready", bus.req_ready, 0);
        rst = 1'b0;
        sb.delete();
        hold_chk = 0;
        #1;
        chk("flush_post_req_ready", bus.req_ready, 1);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("no_stale", bus.rsp_valid, 0);
        end

        // Latency after reset
        send(0, 8, 0, 32767, 0, 0);
        drain();
        chk("latency", last_lat, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/twiddle_gen.md
Name: twiddle_gen

Overview:
Runtime-configurable FFT twiddle-factor generator. It is the parametrised successor to the fixed 256-point combinational twiddle ROM. It stores a single quarter-wave cosine table sized for N_MAX and serves any FFT size 2^L ≤ N_MAX, in forward or inverse mode. Requests and responses use a 2-stage pipelined valid/ready interface with full backpressure, feeding the butterfly datapath of fft_core.

Parameters:
N_MAX, 1024, largest supported FFT size; power of two, ≥8.
WIDTH, 16, signed output width (Q1.(WIDTH-1)).
LOG2N_MAX, $clog2(N_MAX), derived; not to be overridden.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_log2n  in  $clog2(LOG2N_MAX+1)  L, FFT size is 2^L; sampled per request
cfg_inverse  in  1  1 = conjugate twiddle (IFFT); sampled per request
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid & req_ready
req_idx  in  LOG2N_MAX-1  twiddle index k, 0 ≤ k < 2^(L-1)
rsp_valid  out  1  response valid
rsp_ready  in  1  downstream accepts response
rsp_re  out  WIDTH  round(A·cos(2πk/2^L))
rsp_im  out  WIDTH  −round(A·sin(2πk/2^L)); sign flipped when inverse
rsp_idx  out  LOG2N_MAX-1  echo of accepted req_idx

Behaviour:
- Clocking: one clock. Reset is synchronous, active-high.
- Amplitude: A = 2^(WIDTH-1)−1. Full scale saturates to +32767 for WIDTH=16 and never wraps to −32768.
- Table: C[j] = round-half-away-from-zero(A·cos(2πj/N_MAX)), for j = 0..N_MAX/4 (N_MAX/4+1 entries). It is computed at elaboration by a constant function and inferred as ROM. C[N_MAX/4] = 0.
- Config sanitising: L < 2 or L > LOG2N_MAX is treated as L = LOG2N_MAX.
- Index masking: k is masked to its low L−1 bits, i.e. taken modulo 2^(L-1).
- Scaling: m = k_masked << (LOG2N_MAX−L), so 0 ≤ m < N_MAX/2. Let Q = N_MAX/4.
- Folding:
  - m < Q: re = C[m], im = −C[Q−m].
  - m ≥ Q, with m' = m−Q: re = −C[Q−m'], im = −C[m'].
  - If inverse is set, im is negated.
  - Negation of 0 gives 0. No value leaves the range ±A.
- Stage 1 (accept): captures folded ROM address(es), the negation flags, inverse, and idx. Sets s1_valid.
- Stage 2 (read): registers C lookups, applies the negations, and drives rsp_* registers. Sets rsp_valid.
- Latency: a request accepted at cycle t gives rsp_valid at t+2 when unstalled. Throughput is 1 per cycle.
- Flow control:
  - Stage 2 loads when !rsp_valid | rsp_ready.
  - Stage 1 advances into stage 2 under that same condition.
  - req_ready = !s1_valid | stage-2-load. It is combinational and has no path from req_valid.
- Hold: while rsp_valid & !rsp_ready, rsp_re, rsp_im and rsp_idx hold stable. At most 2 requests are in flight, with no loss or duplication.
- Config isolation: cfg_* changes affect only requests accepted after the change.
- Simultaneous events: a response handshake and a new request in the same cycle are both honoured. The pipeline shifts.
- Reset:
  - rsp_valid = 0, rsp_re = 0, rsp_im = 0, rsp_idx = 0, and internal valids = 0.
  - req_ready = 0 while rst is high, and 1 in the first cycle after.
  - Reset mid-operation discards all in-flight requests. No response appears for them.

Test Plan:
- N_MAX=1024, W=16, L=8, forward; k = 0, 1, 32, 64, 127. Required (re, im): (32767, 0), (32757, −804), (23170, −23170), (0, −32767), (−32757, −804).
- L=10, k=1 -> (32766, −201). Same k=1 with L=8 -> (32757, −804). This proves per-request cfg sampling under back-to-back requests.
- Inverse, L=8, k=32 -> (23170, +23170). Illegal L=1 then L=15, k=1 -> treated as L=10: (32766, −201). L=8, k=200 -> masked to 72. Sweep all L in 2..10 and all k against the float model, expecting |err| ≤ 1 LSB.
- Backpressure: stream k = 0..15 continuously, rsp_ready toggling randomly at 50%. Required: 16 responses, in order, with idx echoed. Outputs stay stable while stalled. req_ready drops only when both stages are full.
- Reset for 1 cycle with 2 requests in flight. Required: rsp_valid = 0 next cycle, no stale response afterwards, req_ready = 1 the cycle after reset deasserts. Then a request k=0 at t gives a response at t+2.
